std_sync_read_buf: RTL and testbench
====================================

// Module: std_sync_read_buf
// PURPOSE
//   Downstream consumer stage for an M-structure sync register (read_en/read_done/out port).
//   Issues reads whenever buffer space exists and captures each one-cycle-valid value.
//   Queues captured values in a DEPTH-entry FIFO and presents them as a valid/ready stream.
//   This decouples the blocking register from a consumer that may stall.
// PARAMETERS
//   WIDTH  32  data width; equals WIDTH of the attached sync register
//   DEPTH  4   FIFO entries; power of two, >= 2
// PORTS
//   clk            in   1                    clock; all state on posedge
//   reset          in   1                    asynchronous, active-low (0 = in reset)
//   sreg_read_en   out  1                    to sync register read_en
//   sreg_out       in   WIDTH                from sync register out; valid only when sreg_read_done=1
//   sreg_read_done in   1                    from sync register read_done
//   deq_data       out  WIDTH                head-of-queue value
//   deq_valid      out  1                    deq_data is valid
//   deq_ready      in   1                    consumer accepts; pop when deq_valid && deq_ready
//   count          out  $clog2(DEPTH+1)      number of entries currently held
// BEHAVIOUR
//   Reset values (async assert, sync deassert on clk): sreg_read_en=0, deq_valid=0, deq_data=0,
//     count=0, FSM=RD_IDLE, pointers=0.
//   FSM, 2 states. sreg_read_en is registered and equals 1 exactly when the FSM is in RD_REQ.
//     RD_IDLE -> RD_REQ   when count_next < DEPTH (one slot reserved for the in-flight read).
//     RD_REQ  holds sreg_read_en=1 until sreg_read_done=1 (sync-register protocol).
//     RD_REQ, read_done=1: if count_next < DEPTH, stay RD_REQ (back-to-back reads); else -> RD_IDLE.
//   count_next = count + push - pop.
//   Capture: push sreg_out into FIFO only in cycles with sreg_read_done=1; sreg_out is ignored
//     (may be X) otherwise.
//   Latency: read_done in cycle t -> deq_valid=1 with that value in cycle t+1 (queue empty case).
//   Ordering: strict FIFO. Throughput: one value per cycle sustained when deq_ready=1.
//   Simultaneous push and pop: both occur and count is unchanged; legal at any count, including DEPTH-1.
//   Full: a push at count==DEPTH is impossible by the reservation rule. The bench asserts this never happens.
//   Empty: deq_valid=0 and deq_data holds its last value. A pop request while empty is ignored.
//   Pointers wrap modulo DEPTH. count saturates structurally at DEPTH.
//   Reset mid-handshake: sreg_read_en drops immediately and the queued data is lost. This block's
//     reset must be driven together with the sync register's reset (same net, inverted polarity),
//     so the read_en-until-read_done rule is never violated outside reset.
// CONFIGURATION
//   STD_SYNC_READ_BUF_BYPASS_EN defined:
//     when count==0 and sreg_read_done=1, deq_valid=1 and deq_data=sreg_out combinationally in the same cycle.
//     If deq_ready=1 in that cycle, the value is consumed and not pushed.
//     Latency is 0 cycles.
//   Not defined: no combinational path from sreg_* to deq_*. Latency is 1 cycle as above.
// STRUCTURE
//   Package sync_pkg: typedef enum logic {RD_IDLE, RD_REQ} sync_rd_state_e; and localparam helpers for count width.
//   Sub-module std_sync_buf_fifo (WIDTH, DEPTH): storage array, wrap pointers, count, push/pop, registered head.
//   Top level: FSM, reservation logic, optional bypass mux.
// TESTING  (WIDTH=32, DEPTH=4)
//   1. Hold reset=0 with the register full -> all outputs 0, no read. Release -> sreg_read_en=1 on the next edge.
//   2. deq_ready=0; producer writes 1,2,3,4,5 -> four read_done pulses, count=4, read_en=0 after the 4th,
//      5 stays in the register. Then deq_ready=1 -> deq_data sequence 1,2,3,4,5.
//   3. Producer refills every cycle, deq_ready=1 -> read_en stays 1 continuously, one deq per read_done, count<=1.
//   4. count=3, read_done and pop in the same cycle -> count stays 3, read_en stays 1, order preserved.
//   5. Drive reset=0 while read_en=1 and count=2 -> read_en falls without a clock edge, count=0, deq_valid=0.
//   6. read_done with value 0xDEAD_BEEF, queue empty, deq_ready=1:
//      BYPASS_EN -> accepted in the same cycle, count stays 0;
//      otherwise -> deq_valid rises the next cycle.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and width helpers for the sync-register read buffer.
package sync_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_REQ  = 1'b1
  } sync_rd_state_e;

  // Enough bits to hold every occupancy from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/std_sync_buf_fifo.sv
// DEPTH-entry FIFO with wrapping pointers and a registered head-of-queue value.
module std_sync_buf_fifo
  import sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          head_valid,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] head_q;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_COUNT);
  assign do_pop     = pop && !empty;
  // A push into a full queue is only accepted when a pop frees a slot in the same cycle.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The head register always mirrors mem[rd_ptr]; when the queue holds a single entry
  // and is refilled while popping, the new element has not reached mem yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
    end else if (do_pop) begin
      if (count_q != ONE_COUNT) begin
        head_q <= mem[rd_ptr_inc];
      end else if (do_push) begin
        head_q <= push_data;
      end
    end else if (empty && do_push) begin
      head_q <= push_data;
    end
  end

  assign head_data  = head_q;
  assign head_valid = !empty;
  assign count      = count_q;

endmodule

// File: rtl/std_sync_read_buf.sv
// Read-side buffer for an M-structure sync register; optional same-cycle bypass
// is enabled by defining STD_SYNC_READ_BUF_BYPASS_EN.
module std_sync_read_buf
  import sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          sreg_read_en,
  input  logic [WIDTH-1:0]              sreg_out,
  input  logic                          sreg_read_done,
  output logic [WIDTH-1:0]              deq_data,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CNT_W = count_width(DEPTH);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  sync_rd_state_e   state_q;
  sync_rd_state_e   state_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   count_next;
  logic             slot_free;

`ifdef STD_SYNC_READ_BUF_BYPASS_EN
  logic bypass_hit;

  // With an empty queue the freshly read value goes straight to the consumer and
  // is only queued if the consumer does not take it this cycle.
  assign bypass_hit = (fifo_count == '0) && sreg_read_done;
  assign deq_valid  = fifo_valid || bypass_hit;
  assign deq_data   = bypass_hit ? sreg_out : fifo_head;
  assign fifo_push  = sreg_read_done && !(bypass_hit && deq_ready);
`else
  assign deq_valid  = fifo_valid;
  assign deq_data   = fifo_head;
  assign fifo_push  = sreg_read_done;
`endif

  assign fifo_pop   = fifo_valid && deq_ready;
  assign count_next = {1'b0, fifo_count} + (CNT_W + 1)'(fifo_push) - (CNT_W + 1)'(fifo_pop);
  // A read may only be outstanding while a slot is guaranteed for its result.
  assign slot_free  = (count_next < DEPTH_EXT);

  std_sync_buf_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (sreg_out),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Once raised, read_en must stay up until the register answers with read_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: begin
        if (slot_free) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (sreg_read_done && !slot_free) begin
          state_d = RD_IDLE;
        end
      end
    endcase
  end

  assign sreg_read_en = (state_q == RD_REQ);
  assign count        = fifo_count;

endmodule

// File: tb/tb_std_sync_read_buf.sv
// Directed self-checking bench for std_sync_read_buf (WIDTH=32, DEPTH=4); expectations
// follow STD_SYNC_READ_BUF_BYPASS_EN when it is defined.
module tb_std_sync_read_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             sreg_read_en;
  logic [WIDTH-1:0] sreg_out;
  logic             sreg_read_done;
  logic [WIDTH-1:0] deq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [2:0]       count;

  int vectors     = 0;
  int miscompares = 0;

  std_sync_read_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sreg_read_en   (sreg_read_en),
    .sreg_out       (sreg_out),
    .sreg_read_done (sreg_read_done),
    .deq_data       (deq_data),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled once they settle.
  task automatic drive(input logic done, input logic [31:0] data, input logic ready);
    sreg_read_done = done;
    sreg_out       = data;
    deq_ready      = ready;
    #1;
    check("no_push_when_full", 32'(count == 3'd4 && sreg_read_done), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    sreg_read_done = 1'b0;
    sreg_out       = '0;
    deq_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset held with the register full: no read request, everything cleared.
    drive(1'b0, 32'd0, 1'b0);
    check("rst_read_en",   32'(sreg_read_en), 32'd0);
    check("rst_deq_valid", 32'(deq_valid),    32'd0);
    check("rst_deq_data",  deq_data,          32'd0);
    check("rst_count",     32'(count),        32'd0);
    reset = 1'b1;
    #1;
    check("release_no_edge_read_en", 32'(sreg_read_en), 32'd0);
    tick();
    check("release_read_en", 32'(sreg_read_en), 32'd1);

    // Stalled consumer: four reads fill the queue, the fifth value stays upstream.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      check("fill_read_en", 32'(sreg_read_en), 32'd1);
      check("fill_count",   32'(count),        32'(i - 1));
      tick();
    end
    drive(1'b0, 32'd0, 1'b0);
    check("full_count",     32'(count),        32'd4);
    check("full_read_en",   32'(sreg_read_en), 32'd0);
    check("full_deq_valid", 32'(deq_valid),    32'd1);
    check("full_deq_data",  deq_data,          32'd1);
    tick();
    check("full_hold_read_en", 32'(sreg_read_en), 32'd0);
    drive(1'b0, 32'd0, 1'b1);
    check("drain_data_1", deq_data, 32'd1);
    tick();
    check("drain_read_en", 32'(sreg_read_en), 32'd1);
    check("drain_count_3", 32'(count),        32'd3);
    drive(1'b1, 32'd5, 1'b1);
    check("drain_data_2", deq_data, 32'd2);
    tick();
    check("drain_count_after_5", 32'(count), 32'd3);
    drive(1'b0, 32'd0, 1'b1);
    check("drain_data_3", deq_data, 32'd3);
    tick();
    check("drain_data_4", deq_data, 32'd4);
    tick();
    check("drain_data_5", deq_data,    32'd5);
    check("drain_count_1", 32'(count), 32'd1);
    tick();
    check("empty_deq_valid", 32'(deq_valid), 32'd0);
    check("empty_data_held", deq_data,       32'd5);
    check("empty_count",     32'(count),     32'd0);
    tick();
    check("empty_pop_ignored", 32'(count), 32'd0);

    // Producer refills every cycle, consumer always ready.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h100 + 32'(k), 1'b1);
      check("stream_read_en", 32'(sreg_read_en), 32'd1);
`ifdef STD_SYNC_READ_BUF_BYPASS_EN
      check("stream_count",     32'(count),     32'd0);
      check("stream_deq_valid", 32'(deq_valid), 32'd1);
      check("stream_deq_data",  deq_data,       32'h100 + 32'(k));
`else
      if (k == 0) begin
        check("stream_first_valid", 32'(deq_valid), 32'd0);
      end else begin
        check("stream_count",     32'(count),     32'd1);
        check("stream_deq_valid", 32'(deq_valid), 32'd1);
        check("stream_deq_data",  deq_data,       32'h100 + 32'(k - 1));
      end
`endif
      tick();
    end
    drive(1'b0, 32'd0, 1'b1);
`ifdef STD_SYNC_READ_BUF_BYPASS_EN
    check("stream_tail_valid", 32'(deq_valid), 32'd0);
`else
    check("stream_tail_data", deq_data, 32'h105);
    tick();
`endif
    check("stream_end_count", 32'(count), 32'd0);

    // Push and pop together at count 3.
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'h20 + 32'(j), 1'b0);
      tick();
    end
    drive(1'b1, 32'h23, 1'b1);
    check("pp_count_before",   32'(count),        32'd3);
    check("pp_read_en_before", 32'(sreg_read_en), 32'd1);
    check("pp_data_20",        deq_data,          32'h20);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    check("pp_count_after",   32'(count),        32'd3);
    check("pp_read_en_after", 32'(sreg_read_en), 32'd1);
    check("pp_data_21",       deq_data,          32'h21);
    tick();
    check("pp_data_22", deq_data, 32'h22);
    tick();
    check("pp_data_23", deq_data, 32'h23);
    tick();
    check("pp_empty", 32'(deq_valid), 32'd0);

    // Asynchronous reset in the middle of an open request.
    drive(1'b1, 32'h30, 1'b0);
    tick();
    drive(1'b1, 32'h31, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    check("mid_count",   32'(count),        32'd2);
    check("mid_read_en", 32'(sreg_read_en), 32'd1);
    reset = 1'b0;
    #1;
    check("async_read_en",   32'(sreg_read_en), 32'd0);
    check("async_count",     32'(count),        32'd0);
    check("async_deq_valid", 32'(deq_valid),    32'd0);
    check("async_deq_data",  deq_data,          32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rerelease_read_en", 32'(sreg_read_en), 32'd1);

    // Single value into an empty queue with a ready consumer.
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
`ifdef STD_SYNC_READ_BUF_BYPASS_EN
    check("lat_same_valid", 32'(deq_valid), 32'd1);
    check("lat_same_data",  deq_data,       32'hDEAD_BEEF);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    check("lat_count",      32'(count),     32'd0);
    check("lat_next_valid", 32'(deq_valid), 32'd0);
`else
    check("lat_same_valid", 32'(deq_valid), 32'd0);
    tick();
    drive(1'b0, 32'd0, 1'b1);
    check("lat_next_valid", 32'(deq_valid), 32'd1);
    check("lat_next_data",  deq_data,       32'hDEAD_BEEF);
    check("lat_count",      32'(count),     32'd1);
    tick();
    check("lat_drained", 32'(count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
